// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register write-latency tracker for the ID stage.
// Holds a countdown per architectural register until an issued write is
// forwardable, stalls ID on RAW/WAW conflicts, and gates instruction issue.
// Optional build macro SCOREBOARD_STATS_EN adds a saturating stall counter
// output (stall_count).
module reg_scoreboard #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned LAT_W    = 3,
  parameter int unsigned NUM_REGS = 1 << ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [ADDR_W-1:0]   id_rs,
  input  logic [ADDR_W-1:0]   id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic [ADDR_W-1:0]   id_rd,
  input  logic                id_regwrite,
  input  logic [LAT_W-1:0]    id_lat,
  input  logic                flush,
  output logic                stall,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_mask
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [15:0]         stall_count
`endif
);

  localparam int unsigned STAT_W = 16;

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic             raw_rs;
  logic             raw_rt;
  logic             waw;

  // Hazard detection against the pre-update counters; own write never stalls itself.
  always_comb begin
    raw_rs = id_use_rs & (cnt[id_rs] != '0);
    raw_rt = id_use_rt & (cnt[id_rt] != '0);
    waw    = id_regwrite & (cnt[id_rd] > id_lat);
    stall  = id_valid & ~flush & (raw_rs | raw_rt | waw);
    issue  = id_valid & ~flush & ~stall;
  end

  // Busy view taken straight from the registered counters.
  always_comb begin
    busy_mask = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      busy_mask[r] = (cnt[r] != '0);
    end
  end

  // Countdown per register: a new issued write reloads, otherwise count down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (issue && id_regwrite && (id_rd == ADDR_W'(r))) begin
          cnt[r] <= id_lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
    end
  end

`ifdef SCOREBOARD_STATS_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {STAT_W{1'b1}})) begin
      stall_count <= stall_count + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard: scenario tasks drive steps, push the expected
// {stall, issue, busy_mask} into a queue and pop/compare at the falling edge.
module tb_reg_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [2:0] id_rd;
  logic       id_regwrite;
  logic [2:0] id_lat;
  logic       flush;
  logic       stall;
  logic       issue;
  logic [7:0] busy_mask;
`ifdef SCOREBOARD_STATS_EN
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic [2:0] rd;
    logic       rw;
    logic [2:0] lat;
    logic       fl;
    logic [9:0] exp;
  } step_t;

  logic [9:0] exp_q[$];

  reg_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_lat      (id_lat),
    .flush       (flush),
    .stall       (stall),
    .issue       (issue),
    .busy_mask   (busy_mask)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic step_t st(input logic rst, input logic v,
                               input logic [2:0] rs, input logic [2:0] rt,
                               input logic urs, input logic urt,
                               input logic [2:0] rd, input logic rw,
                               input logic [2:0] lat, input logic fl,
                               input logic e_stall, input logic e_issue,
                               input logic [7:0] e_busy);
    step_t s;
    s.rst = rst; s.v = v; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt;
    s.rd = rd; s.rw = rw; s.lat = lat; s.fl = fl;
    s.exp = {e_stall, e_issue, e_busy};
    return s;
  endfunction

  // Drive one step just after the rising edge and record its expectation.
  task automatic apply(input step_t s);
    @(posedge clk);
    #1;
    rst_n       = s.rst;
    id_valid    = s.v;
    id_rs       = s.rs;
    id_rt       = s.rt;
    id_use_rs   = s.urs;
    id_use_rt   = s.urt;
    id_rd       = s.rd;
    id_regwrite = s.rw;
    id_lat      = s.lat;
    flush       = s.fl;
    exp_q.push_back(s.exp);
  endtask

  task automatic test_reset();
    step_t t[$];
    logic [9:0] want;
    t.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    t.push_back(st(1, 1, 0, 0, 0, 0, 2, 1, 5, 0, 0, 1, 8'h00));
    t.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h04));
    t.push_back(st(0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 1, 8'h00));
    t.push_back(st(1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 1, 8'h00));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if ({stall, issue, busy_mask} !== want) begin
        errors++;
        $display("FAIL reset step %0d got stall=%b issue=%b busy=%h want stall=%b issue=%b busy=%h",
                 i, stall, issue, busy_mask, want[9], want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_load_use();
    step_t t[$];
    logic [9:0] want;
    t.push_back(st(1, 1, 0, 0, 0, 0, 3, 1, 2, 0, 0, 1, 8'h00));
    t.push_back(st(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h08));
    t.push_back(st(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h08));
    t.push_back(st(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 8'h00));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if ({stall, issue, busy_mask} !== want) begin
        errors++;
        $display("FAIL load_use step %0d got stall=%b issue=%b busy=%h want stall=%b issue=%b busy=%h",
                 i, stall, issue, busy_mask, want[9], want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_no_hazard();
    step_t t[$];
    logic [9:0] want;
    t.push_back(st(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 8'h00));
    t.push_back(st(1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 8'h00));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if ({stall, issue, busy_mask} !== want) begin
        errors++;
        $display("FAIL no_hazard step %0d got stall=%b issue=%b busy=%h want stall=%b issue=%b busy=%h",
                 i, stall, issue, busy_mask, want[9], want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_waw();
    step_t t[$];
    logic [9:0] want;
    t.push_back(st(1, 1, 0, 0, 0, 0, 5, 1, 4, 0, 0, 1, 8'h00));
    t.push_back(st(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 1, 0, 8'h20));
    t.push_back(st(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 1, 0, 8'h20));
    t.push_back(st(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 1, 0, 8'h20));
    t.push_back(st(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1, 8'h20));
    t.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h20));
    t.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if ({stall, issue, busy_mask} !== want) begin
        errors++;
        $display("FAIL waw step %0d got stall=%b issue=%b busy=%h want stall=%b issue=%b busy=%h",
                 i, stall, issue, busy_mask, want[9], want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_flush_simul();
    step_t t[$];
    logic [9:0] want;
    t.push_back(st(1, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 1, 8'h00));
    t.push_back(st(1, 1, 0, 0, 0, 0, 6, 1, 3, 0, 0, 1, 8'h40));
    t.push_back(st(1, 1, 6, 0, 1, 0, 0, 0, 0, 1, 0, 0, 8'h40));
    t.push_back(st(1, 1, 6, 0, 1, 0, 0, 0, 0, 1, 0, 0, 8'h40));
    t.push_back(st(1, 1, 6, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h40));
    t.push_back(st(1, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 1, 8'h00));
    t.push_back(st(1, 1, 6, 6, 1, 1, 6, 1, 3, 0, 0, 1, 8'h00));
    t.push_back(st(1, 1, 6, 6, 0, 0, 2, 1, 0, 0, 0, 1, 8'h40));
    t.push_back(st(1, 1, 0, 6, 0, 1, 0, 0, 0, 0, 1, 0, 8'h40));
    t.push_back(st(1, 0, 0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 8'h40));
    t.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if ({stall, issue, busy_mask} !== want) begin
        errors++;
        $display("FAIL flush_simul step %0d got stall=%b issue=%b busy=%h want stall=%b issue=%b busy=%h",
                 i, stall, issue, busy_mask, want[9], want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t t[$];
    logic [9:0] want;
    t.push_back(st(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 8'h00));
    t.push_back(st(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h01));
    t.push_back(st(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 8'h00));
    t.push_back(st(1, 1, 0, 0, 0, 0, 7, 1, 3, 0, 0, 1, 8'h00));
    t.push_back(st(1, 1, 0, 0, 0, 0, 7, 1, 2, 0, 1, 0, 8'h80));
    t.push_back(st(1, 1, 0, 0, 0, 0, 7, 1, 2, 0, 0, 1, 8'h80));
    t.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h80));
    t.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h80));
    t.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if ({stall, issue, busy_mask} !== want) begin
        errors++;
        $display("FAIL back_to_back step %0d got stall=%b issue=%b busy=%h want stall=%b issue=%b busy=%h",
                 i, stall, issue, busy_mask, want[9], want[8], want[7:0]);
      end
    end
  endtask

`ifdef SCOREBOARD_STATS_EN
  task automatic test_stats();
    step_t t[$];
    logic [9:0] want;
    t.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    t.push_back(st(1, 1, 0, 0, 0, 0, 4, 1, 3, 0, 0, 1, 8'h00));
    t.push_back(st(1, 1, 4, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h10));
    t.push_back(st(1, 1, 4, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h10));
    t.push_back(st(1, 1, 4, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h10));
    t.push_back(st(1, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1, 8'h00));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if ({stall, issue, busy_mask} !== want) begin
        errors++;
        $display("FAIL stats step %0d got stall=%b issue=%b busy=%h want stall=%b issue=%b busy=%h",
                 i, stall, issue, busy_mask, want[9], want[8], want[7:0]);
      end
    end
    checks++;
    if (stall_count !== 16'd3) begin
      errors++;
      $display("FAIL stats_count3 got %0d want 3", stall_count);
    end
    // Read-and-rewrite r4 with latency 7: 7 of every 8 cycles stall.
    apply(st(1, 1, 4, 0, 1, 0, 4, 1, 7, 0, 0, 1, 8'h00));
    void'(exp_q.pop_front());
    repeat (80000) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_saturate got %h want ffff", stall_count);
    end
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    void'(exp_q.pop_front());
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    id_valid    = 1'b0;
    id_rs       = '0;
    id_rt       = '0;
    id_use_rs   = 1'b0;
    id_use_rt   = 1'b0;
    id_rd       = '0;
    id_regwrite = 1'b0;
    id_lat      = '0;
    flush       = 1'b0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_waw();
    test_flush_simul();
    test_back_to_back();
`ifdef SCOREBOARD_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
